data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the RV32IM pipeline's memory stage and the block-oriented data memory. Serves the CPU's `memReadEn`/`memWriteEn`/`DATA_CACHE_ADDR`/`DATA_CACHE_DATA` request and returns `DATA_CACHE_READ_DATA`. `DATA_CACHE_BUSY_WAIT` freezes the pipeline while a miss is serviced. Memory side moves whole 128-bit blocks under a read/write/busywait handshake.

---
 rtl/dcache_pkg.sv | 40 ++++
 rtl/dcache_lane_align.sv | 49 ++++
 rtl/data_cache.sv | 171 +++++++++++++++++
 tb/tb_data_cache.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: geometry, load/store codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

   localparam int DCACHE_SETS = 8;              // default number of lines
   localparam int BLOCK_WORDS = 4;              // words per line
   localparam int LINE_W      = BLOCK_WORDS * 32;
   localparam int OFFSET_W    = 4;              // byte offset inside a 16 B line
   localparam int ADDR_W      = 32;
   localparam int BLK_ADDR_W  = ADDR_W - OFFSET_W;

   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int sets);
      return ADDR_W - OFFSET_W - $clog2(sets);
   endfunction

   // funct3 load codes (low bits of memReadEn)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // store size codes (low bits of memWriteEn)
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      UPDATE    = 2'd3
   } dcache_state_e;

endpackage

// File: rtl/dcache_lane_align.sv
// Load lane extraction/extension and store lane merge for one 128-bit line.
// Latency: purely combinational.
// Backpressure: none.
// Ports: line/offset select the lane; funct3 picks load width and extension,
//        size/wdata describe the store; load_data and merged_line are results.
module dcache_lane_align
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line,
   input  logic [3:0]        offset,
   input  logic [2:0]        funct3,
   input  logic [1:0]        size,
   input  logic [31:0]       wdata,
   output logic [31:0]       load_data,
   output logic [LINE_W-1:0] merged_line
);

   logic [31:0] word_sel;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Halfword ignores offset[0]; word ignores offset[1:0].
   assign word_sel = line[{offset[3:2], 5'b00000} +: 32];
   assign byte_sel = word_sel[{offset[1:0], 3'b000} +: 8];
   assign half_sel = word_sel[{offset[1], 4'b0000} +: 16];

   always_comb begin
      load_data = '0;
      case (funct3)
         F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_LW:   load_data = word_sel;
         F3_LBU:  load_data = {24'h0, byte_sel};
         F3_LHU:  load_data = {16'h0, half_sel};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      merged_line = line;
      case (size)
         SZ_BYTE: merged_line[{offset, 3'b000} +: 8]             = wdata[7:0];
         SZ_HALF: merged_line[{offset[3:1], 4'b0000} +: 16]      = wdata[15:0];
         SZ_WORD: merged_line[{offset[3:2], 5'b00000} +: 32]     = wdata;
         default: merged_line = line;
      endcase
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache between CPU MEM stage and block memory.
// Latency: hits complete in the request cycle; misses stall for fill (+ writeback if dirty) + 2 cycles.
// Backpressure: DATA_CACHE_BUSY_WAIT stalls the CPU; mem_busywait holds each block transfer.
// Ports: CPU side memReadEn/memWriteEn/DATA_CACHE_ADDR/DATA_CACHE_DATA in,
//        DATA_CACHE_READ_DATA/DATA_CACHE_BUSY_WAIT out; memory side mem_read/mem_write/
//        mem_address/mem_writedata out, mem_readdata/mem_busywait in.
module data_cache
   import dcache_pkg::*;
#(
   parameter int SETS = DCACHE_SETS
)
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [3:0]            memReadEn,
   input  logic [2:0]            memWriteEn,
   input  logic [31:0]           DATA_CACHE_ADDR,
   input  logic [31:0]           DATA_CACHE_DATA,
   output logic [31:0]           DATA_CACHE_READ_DATA,
   output logic                  DATA_CACHE_BUSY_WAIT,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [BLK_ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0]     mem_writedata,
   input  logic [LINE_W-1:0]     mem_readdata,
   input  logic                  mem_busywait
);

   localparam int IDX_W = index_w(SETS);
   localparam int TAG_W = tag_w(SETS);

   // request decode
   logic             rd_req, wr_req, req;
   logic [3:0]       offset;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;

   assign rd_req = memReadEn[3];
   assign wr_req = memWriteEn[2];
   assign req    = rd_req | wr_req;
   assign offset = DATA_CACHE_ADDR[3:0];
   assign idx    = DATA_CACHE_ADDR[OFFSET_W +: IDX_W];
   assign tag    = DATA_CACHE_ADDR[ADDR_W-1 -: TAG_W];

   // line storage; data/tag are not reset, only valid/dirty are
   logic [LINE_W-1:0] data_arr [SETS];
   logic [TAG_W-1:0]  tag_arr  [SETS];
   logic [SETS-1:0]   valid_bits;
   logic [SETS-1:0]   dirty_bits;
   logic [LINE_W-1:0] fill_buf;

   dcache_state_e state, state_next;

   logic              line_hit, line_dirty, miss, do_store;
   logic [LINE_W-1:0] cur_line, merged_line;
   logic [31:0]       load_data;

   assign cur_line   = data_arr[idx];
   assign line_hit   = valid_bits[idx] && (tag_arr[idx] == tag);
   assign line_dirty = valid_bits[idx] && dirty_bits[idx];

   dcache_lane_align u_lane_align (
      .line        (cur_line),
      .offset      (offset),
      .funct3      (memReadEn[2:0]),
      .size        (memWriteEn[1:0]),
      .wdata       (DATA_CACHE_DATA),
      .load_data   (load_data),
      .merged_line (merged_line)
   );

   // ---------------- FSM: next state and CPU-facing outputs ----------------
   always_comb begin
      state_next           = state;
      miss                 = 1'b0;
      do_store             = 1'b0;
      DATA_CACHE_BUSY_WAIT = 1'b0;
      DATA_CACHE_READ_DATA = '0;

      case (state)
         IDLE: begin
            miss     = req && !line_hit;
            do_store = wr_req && line_hit;
            if (miss) begin
               state_next = line_dirty ? WRITEBACK : ALLOCATE;
            end
            // A store takes priority when both enables are up, so no load data then.
            if (rd_req && !wr_req && line_hit) begin
               DATA_CACHE_READ_DATA = load_data;
            end
         end
         WRITEBACK: if (!mem_busywait) state_next = ALLOCATE;
         ALLOCATE:  if (!mem_busywait) state_next = UPDATE;
         UPDATE:    state_next = IDLE;
         default:   state_next = IDLE;
      endcase

      DATA_CACHE_BUSY_WAIT = miss || (state != IDLE);

      // While reset is held every output is forced low, even with a request pending.
      if (!RESET) begin
         DATA_CACHE_BUSY_WAIT = 1'b0;
         DATA_CACHE_READ_DATA = '0;
      end
   end

   // ---------------- FSM state, line status and memory-side registers ----------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state         <= IDLE;
         valid_bits    <= '0;
         dirty_bits    <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
      end else begin
         state <= state_next;

         case (state)
            IDLE: begin
               if (miss && line_dirty) begin
                  mem_write     <= 1'b1;
                  mem_address   <= {tag_arr[idx], idx};
                  mem_writedata <= cur_line;
               end else if (miss) begin
                  mem_read    <= 1'b1;
                  mem_address <= DATA_CACHE_ADDR[ADDR_W-1:OFFSET_W];
               end
               if (do_store) begin
                  dirty_bits[idx] <= 1'b1;
               end
            end
            WRITEBACK: begin
               // Write-back done: switch straight over to the fetch, never overlapping.
               if (!mem_busywait) begin
                  mem_write     <= 1'b0;
                  mem_writedata <= '0;
                  mem_read      <= 1'b1;
                  mem_address   <= DATA_CACHE_ADDR[ADDR_W-1:OFFSET_W];
               end
            end
            ALLOCATE: begin
               if (!mem_busywait) begin
                  mem_read    <= 1'b0;
                  mem_address <= '0;
               end
            end
            UPDATE: begin
               valid_bits[idx] <= 1'b1;
               dirty_bits[idx] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ---------------- data/tag arrays and fill buffer ----------------
   always_ff @(posedge CLK) begin
      if (state == ALLOCATE && !mem_busywait) begin
         fill_buf <= mem_readdata;
      end
      if (state == UPDATE) begin
         data_arr[idx] <= fill_buf;
         tag_arr[idx]  <= tag;
      end else if (do_store) begin
         data_arr[idx] <= merged_line;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a fixed-latency block memory model.
// Latency: memory answers LAT+1 cycles after a request is raised.
// Backpressure: memory holds mem_busywait high until its counter expires.
module tb_data_cache;
   import dcache_pkg::*;

   localparam int LAT = 4;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [3:0]   memReadEn;
   logic [2:0]   memWriteEn;
   logic [31:0]  addr_in, data_in;
   logic [31:0]  rdata;
   logic         busy;
   logic         mem_read, mem_write, mem_busywait;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata, mem_readdata;

   int n_checks  = 0;
   int n_fail    = 0;
   int both_high = 0;

   data_cache dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .memReadEn            (memReadEn),
      .memWriteEn           (memWriteEn),
      .DATA_CACHE_ADDR      (addr_in),
      .DATA_CACHE_DATA      (data_in),
      .DATA_CACHE_READ_DATA (rdata),
      .DATA_CACHE_BUSY_WAIT (busy),
      .mem_read             (mem_read),
      .mem_write            (mem_write),
      .mem_address          (mem_address),
      .mem_writedata        (mem_writedata),
      .mem_readdata         (mem_readdata),
      .mem_busywait         (mem_busywait)
   );

   always #5 CLK = ~CLK;

   // ---------------- block memory model ----------------
   logic [127:0] mem_blk [64];
   int           cnt;

   assign mem_busywait = (mem_read || mem_write) && (cnt != LAT);
   assign mem_readdata = mem_blk[mem_address[5:0]];

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) cnt <= 0;
      else if (mem_read || mem_write) cnt <= (cnt == LAT) ? 0 : cnt + 1;
      else cnt <= 0;
   end

   always @(posedge CLK) begin
      if (RESET && mem_write && !mem_busywait) mem_blk[mem_address[5:0]] <= mem_writedata;
   end

   // ---------------- helpers ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] re, input logic [2:0] we,
                        input logic [31:0] a, input logic [31:0] d);
      @(posedge CLK);
      #1;
      memReadEn  = re;
      memWriteEn = we;
      addr_in    = a;
      data_in    = d;
   endtask

   task automatic load_hit(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
      drive({1'b1, f3}, 3'b000, a, 32'h0);
      @(negedge CLK);
      check_eq({tag, "_bw"}, {31'h0, busy}, 32'h0);
      check_eq(tag, rdata, exp);
   endtask

   task automatic store_hit(input string tag, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
      drive(4'b0000, {1'b1, sz}, a, d);
      @(negedge CLK);
      check_eq({tag, "_bw"}, {31'h0, busy}, 32'h0);
   endtask

   // Counts busywait-high cycles of a held miss and records the memory traffic seen.
   task automatic wait_ready(output int cycles, output logic [27:0] wr_addr,
                             output logic [127:0] wr_data, output logic [27:0] rd_addr,
                             output logic wr_first);
      logic seen_wr, seen_rd;
      cycles = 0; seen_wr = 1'b0; seen_rd = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0; wr_first = 1'b0;
      @(negedge CLK);
      while (busy && cycles < 100) begin
         cycles++;
         if (mem_read && mem_write) both_high++;
         if (mem_write && !seen_wr) begin
            seen_wr = 1'b1; wr_addr = mem_address; wr_data = mem_writedata;
         end
         if (mem_read && !seen_rd) begin
            seen_rd = 1'b1; rd_addr = mem_address; wr_first = seen_wr;
         end
         @(negedge CLK);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int           cyc;
      logic [27:0]  wa, ra;
      logic [127:0] wd;
      logic         wf;

      for (int i = 0; i < 64; i++) mem_blk[i] = '0;
      mem_blk[4]  = {32'hCAFE_F00D, 32'h0000_7FFF, 32'h8001_0080, 32'h1234_5678};
      mem_blk[12] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hAAAA_0001};

      RESET = 1'b0; memReadEn = '0; memWriteEn = '0; addr_in = '0; data_in = '0;
      #22;
      check_eq("rst_bw",    {31'h0, busy}, 32'h0);
      check_eq("rst_mrd",   {31'h0, mem_read}, 32'h0);
      check_eq("rst_mwr",   {31'h0, mem_write}, 32'h0);
      check_eq("rst_maddr", {4'h0, mem_address}, 32'h0);
      check_eq("rst_mwd",   mem_writedata[31:0] | mem_writedata[127:96], 32'h0);
      check_eq("rst_rdata", rdata, 32'h0);
      @(negedge CLK);
      RESET = 1'b1;

      // clean miss on LW 0x40
      drive({1'b1, F3_LW}, 3'b000, 32'h40, 32'h0);
      #1;
      check_eq("miss_bw_now",  {31'h0, busy}, 32'h1);
      check_eq("miss_mrd_now", {31'h0, mem_read}, 32'h0);
      wait_ready(cyc, wa, wd, ra, wf);
      check_eq("clean_cycles", cyc, 32'd7);
      check_eq("clean_raddr",  {4'h0, ra}, 32'h4);
      check_eq("clean_nowr",   {4'h0, wa}, 32'h0);
      check_eq("clean_rdata",  rdata, 32'h1234_5678);

      // load extraction / extension on the filled line
      load_hit("lb_44",  F3_LB,  32'h44, 32'hFFFF_FF80);
      load_hit("lbu_44", F3_LBU, 32'h44, 32'h0000_0080);
      load_hit("lh_46",  F3_LH,  32'h46, 32'hFFFF_8001);
      load_hit("lh_47",  F3_LH,  32'h47, 32'hFFFF_8001);
      load_hit("lhu_4e", F3_LHU, 32'h4E, 32'h0000_CAFE);
      load_hit("lw_4b",  F3_LW,  32'h4B, 32'h0000_7FFF);

      // store hits
      store_hit("sb_41", SZ_BYTE, 32'h41, 32'hFFFF_FFAB);
      load_hit("lw_40",  F3_LW,   32'h40, 32'h1234_AB78);
      store_hit("sh_4e", SZ_HALF, 32'h4E, 32'h0000_1234);
      load_hit("lw_4c",  F3_LW,   32'h4C, 32'h1234_F00D);
      store_hit("sw_48", SZ_WORD, 32'h48, 32'hDEAD_BEEF);
      load_hit("lw_48",  F3_LW,   32'h48, 32'hDEAD_BEEF);

      // both enables: behaves as a store, no read data
      drive({1'b1, F3_LW}, {1'b1, SZ_WORD}, 32'h44, 32'h5566_7788);
      @(negedge CLK);
      check_eq("both_bw",    {31'h0, busy}, 32'h0);
      check_eq("both_rdata", rdata, 32'h0);
      load_hit("lw_44", F3_LW, 32'h44, 32'h5566_7788);

      // no request
      drive(4'b0000, 3'b000, 32'h40, 32'h0);
      @(negedge CLK);
      check_eq("noreq_bw",    {31'h0, busy}, 32'h0);
      check_eq("noreq_rdata", rdata, 32'h0);

      // dirty miss: LW 0xC0 evicts the dirty line at index 4
      drive({1'b1, F3_LW}, 3'b000, 32'hC0, 32'h0);
      #1;
      check_eq("dirty_bw_now", {31'h0, busy}, 32'h1);
      wait_ready(cyc, wa, wd, ra, wf);
      check_eq("dirty_cycles", cyc, 32'd12);
      check_eq("wb_addr",      {4'h0, wa}, 32'h4);
      check_eq("wb_word0",     wd[31:0], 32'h1234_AB78);
      check_eq("wb_word3",     wd[127:96], 32'h1234_F00D);
      check_eq("fill_addr",    {4'h0, ra}, 32'hC);
      check_eq("wb_before_rd", {31'h0, wf}, 32'h1);
      check_eq("dirty_rdata",  rdata, 32'hAAAA_0001);
      check_eq("mem_blk4_w1",  mem_blk[4][63:32], 32'h5566_7788);
      load_hit("lbu_c3", F3_LBU, 32'hC3, 32'h0000_00AA);
      load_hit("lb_c3",  F3_LB,  32'hC3, 32'hFFFF_FFAA);

      // reset while ALLOCATE is in progress
      drive({1'b1, F3_LW}, 3'b000, 32'h80, 32'h0);
      repeat (3) @(negedge CLK);
      check_eq("alloc_mrd",   {31'h0, mem_read}, 32'h1);
      check_eq("alloc_maddr", {4'h0, mem_address}, 32'h8);
      #2;
      RESET = 1'b0;
      #1;
      check_eq("rstmid_mrd", {31'h0, mem_read}, 32'h0);
      check_eq("rstmid_bw",  {31'h0, busy}, 32'h0);
      memReadEn = '0; memWriteEn = '0; addr_in = '0;
      @(negedge CLK);
      RESET = 1'b1;

      drive({1'b1, F3_LW}, 3'b000, 32'h40, 32'h0);
      #1;
      check_eq("post_rst_miss", {31'h0, busy}, 32'h1);
      wait_ready(cyc, wa, wd, ra, wf);
      check_eq("post_rst_cycles", cyc, 32'd7);
      check_eq("post_rst_rdata",  rdata, 32'h1234_AB78);
      load_hit("post_rst_lw48", F3_LW, 32'h48, 32'hDEAD_BEEF);

      check_eq("both_high", both_high, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
